// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin, non-preemptive single-bus arbiter with a one-cycle turnaround
// and a stall watchdog. Define BUS_ARBITER_PARK_EN to park an idle bus on master 0.
module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int WD_CYCLES   = 255,
    parameter int WD_WIDTH    = 8,
    localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] bus_req,
    output logic [NUM_MASTERS-1:0] bus_grant,
    input  logic                   rd_bus,
    input  logic                   wr_bus,
    input  logic                   fc_bus,
    output logic                   watchdog,
    output logic [IDX_W-1:0]       owner,
    output logic                   bus_busy,
    output logic                   o_dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(WD_CYCLES - 1);

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [WD_WIDTH-1:0]    r_wd_cnt;
    logic                   r_watchdog;
`ifdef BUS_ARBITER_PARK_EN
    logic                   r_parked;
`endif

    logic                   w_stalled;
    logic                   w_found;
    logic [IDX_W-1:0]       w_cand;
    logic [IDX_W-1:0]       w_winner;
    logic [NUM_MASTERS-1:0] w_winner_oh;
    logic                   w_leave;

    // A transfer is stalled when exactly one strobe is active and no completion has come back.
    assign w_stalled = (rd_bus ^ wr_bus) & ~fc_bus;

    // Round-robin search starts one past the last owner and wraps.
    always_comb begin
        w_found     = 1'b0;
        w_cand      = '0;
        w_winner    = r_rr_ptr;
        w_winner_oh = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_cand = IDX_W'((int'(r_rr_ptr) + i) % NUM_MASTERS);
            if (!w_found && bus_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
        w_winner_oh[w_winner] = 1'b1;
    end

    always_comb begin
        w_leave = r_watchdog;
`ifdef BUS_ARBITER_PARK_EN
        if (r_parked) begin
            if (!bus_req[0] && (|bus_req)) begin
                w_leave = 1'b1;
            end
        end else if (!bus_req[r_owner]) begin
            w_leave = 1'b1;
        end
`else
        if (!bus_req[r_owner]) begin
            w_leave = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= IDX_W'(NUM_MASTERS - 1);
            r_wd_cnt   <= '0;
            r_watchdog <= 1'b0;
`ifdef BUS_ARBITER_PARK_EN
            r_parked   <= 1'b0;
`endif
        end else begin
            r_watchdog <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wd_cnt <= '0;
                    if (w_found) begin
                        r_grant  <= w_winner_oh;
                        r_owner  <= w_winner;
                        r_rr_ptr <= w_winner;
                        r_state  <= S_OWNED;
                    end
`ifdef BUS_ARBITER_PARK_EN
                    else begin
                        // Park on the CPU without disturbing round-robin fairness.
                        r_grant  <= NUM_MASTERS'(1);
                        r_owner  <= '0;
                        r_parked <= 1'b1;
                        r_state  <= S_OWNED;
                    end
`endif
                end
                S_OWNED: begin
                    if (w_leave) begin
                        r_grant  <= '0;
                        r_wd_cnt <= '0;
                        r_state  <= S_IDLE;
`ifdef BUS_ARBITER_PARK_EN
                        r_parked <= 1'b0;
`endif
                    end else begin
`ifdef BUS_ARBITER_PARK_EN
                        if (r_parked && bus_req[0]) begin
                            r_parked <= 1'b0;
                            r_rr_ptr <= '0;
                        end
`endif
                        if (w_stalled) begin
                            if (r_wd_cnt == WD_LAST) begin
                                r_watchdog <= 1'b1;
                                r_wd_cnt   <= '0;
                            end else begin
                                r_wd_cnt <= r_wd_cnt + WD_WIDTH'(1);
                            end
                        end else begin
                            r_wd_cnt <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign bus_grant   = r_grant;
    assign watchdog    = r_watchdog;
    assign owner       = r_owner;
    assign bus_busy    = |r_grant;
    assign o_dbg_state = r_state;

endmodule
